dbg_bus_port: RTL and testbench
===============================

Name: dbg_bus_port

Overview:
- Debug injection and snoop port on the CPU's wired-OR word bus.
- Upstream side: buffers words pushed by the debug host in a small FIFO and drives one word onto the bus dbg_in source per granted bus slot. Outputs all-zero at all other times, so the OR-bus stays clean.
- Downstream side: captures one non-idle bus value on request and holds it until the host acknowledges.

Parameters:
- word_width, `WORD_WIDTH: bus word width in bits.
- fifo_depth, 4: injection FIFO entries; power of two, at least 2.
- cnt_width, $clog2(fifo_depth)+1: width of fifo_count; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- host_data  input  word_width  word to inject.
- host_valid  input  1  host_data is valid.
- host_ready  output  1  FIFO can accept a word this cycle.
- bus_slot  input  1  from control: the bus is free for dbg in the NEXT cycle.
- dbg_out  output  word_width  to the bus dbg_in source; zero unless dbg_drive is high.
- dbg_drive  output  1  dbg_out carries a valid word this cycle.
- bus_in  input  word_width  current resolved bus value.
- snoop_req  input  1  arm a one-shot bus capture.
- snoop_data  output  word_width  captured bus word.
- snoop_valid  output  1  snoop_data holds a capture.
- snoop_ack  input  1  host consumed snoop_data.
- fifo_count  output  cnt_width  current FIFO occupancy.

Behaviour:
- Reset: synchronous and active-high; the clock and reset ports are clk and reset. When reset is high at an edge:
  - the FIFO is flushed: pointers and fifo_count go to 0;
  - dbg_out and dbg_drive go to 0;
  - the snoop FSM goes to IDLE: snoop_valid=0, snoop_data=0.
  - A word being driven when reset is applied is dropped; nothing is driven in the cycle after the reset edge.
- host_ready = (fifo_count < fifo_depth), computed from registered state only.
- Push: at an edge where host_valid & host_ready, host_data is written at the write pointer.
- Full FIFO: no push, even if a pop happens in the same cycle.
- Pop/drive:
  - At an edge where bus_slot=1 and fifo_count≠0, the head word is registered into dbg_out, dbg_drive=1, and the read pointer advances.
  - Latency: bus_slot in cycle N gives the word on the bus in cycle N+1 only.
- Default: at any other edge, dbg_out=0 and dbg_drive=0. Never hold a stale word; it would corrupt the OR-bus.
- Empty FIFO with bus_slot high: no drive; dbg_out stays 0.
- No bypass: a push and bus_slot in the same cycle on an empty FIFO gives no drive. The word is driven on the next granted slot.
- Simultaneous push and pop on a non-full, non-empty FIFO: fifo_count is unchanged, and both operations complete.
- Pointers wrap modulo fifo_depth; fifo_count saturates by construction between 0 and fifo_depth.
- Snoop FSM:
  - IDLE: snoop_req=1 → ARMED. snoop_ack is ignored.
  - ARMED: at the first edge where bus_in≠0, snoop_data<=bus_in, snoop_valid<=1 → HOLD. A word driven by this block itself is eligible. snoop_req is ignored.
  - HOLD: snoop_data is frozen. snoop_ack=1 → IDLE and snoop_valid<=0. snoop_req is ignored until IDLE.
  - ack and req asserted together in HOLD: go to IDLE only; the request is not re-armed.
- Snoop and injection are independent and may be active in the same cycle.

Test Plan:
1. Reset, then push 0x1234 and 0x00AB; pulse bus_slot in cycles 5 and 9. Expect dbg_drive high and dbg_out 0x1234 in cycle 6 and 0x00AB in cycle 10; dbg_out=0 in every other cycle; fifo_count 2→1→0.
2. Hold host_valid high with data 1,2,3,4,5 and no slots. Expect host_ready to drop after 4 accepted words, fifo_count=4, and word 5 held by the host. Then one slot: word 1 is driven, ready reasserts, and 5 is accepted the next cycle.
3. Empty FIFO, push 0x0055 and assert bus_slot in the same cycle. Expect no drive the next cycle; a slot 2 cycles later drives 0x0055.
4. Reach fifo_depth wrap: run 10 push/pop pairs with data 0x10..0x19 and simultaneous push+slot once occupancy is 1. Expect in-order output 0x10..0x19 and fifo_count stable at 1 during the overlap.
5. Snoop: pulse snoop_req while bus_in=0 for 3 cycles, then bus_in=0xBEEF. Expect snoop_valid=1 and snoop_data=0xBEEF; later bus values are ignored. Assert snoop_ack → snoop_valid=0 next cycle. A snoop_req during HOLD has no effect.
6. Reset mid-operation: with 3 words queued and dbg_drive high on 0x7777, assert reset. Expect in the next cycle dbg_out=0, dbg_drive=0, fifo_count=0, snoop_valid=0; a later slot drives nothing.

Source files
------------

// File: rtl/dbg_bus_port_if.sv
// Purpose: bundles the host, bus and snoop signals of dbg_bus_port.
// Latency: none (wires only).
// Backpressure: host_ready gates host_valid; bus_slot grants one drive cycle.
//
// Port summary (slave = dbg_bus_port, master = debug host / bus model):
//   host_data/host_valid -> FIFO push, host_ready <- FIFO has room
//   bus_slot             -> bus free for dbg in the next cycle
//   dbg_out/dbg_drive    <- word driven onto the wired-OR bus (zero when idle)
//   bus_in               -> resolved bus value seen by the snoop logic
//   snoop_req/snoop_ack  -> arm a capture / release a held capture
//   snoop_data/valid     <- captured bus word
//   fifo_count           <- current FIFO occupancy

interface dbg_bus_port_if #(
  parameter int word_width = 16,
  parameter int fifo_depth = 4
);
  localparam int cnt_width = $clog2(fifo_depth) + 1;

  logic [word_width-1:0] host_data;
  logic                  host_valid;
  logic                  host_ready;
  logic                  bus_slot;
  logic [word_width-1:0] dbg_out;
  logic                  dbg_drive;
  logic [word_width-1:0] bus_in;
  logic                  snoop_req;
  logic [word_width-1:0] snoop_data;
  logic                  snoop_valid;
  logic                  snoop_ack;
  logic [cnt_width-1:0]  fifo_count;

  modport slave (
    input  host_data, host_valid, bus_slot, bus_in, snoop_req, snoop_ack,
    output host_ready, dbg_out, dbg_drive, snoop_data, snoop_valid, fifo_count
  );

  modport master (
    output host_data, host_valid, bus_slot, bus_in, snoop_req, snoop_ack,
    input  host_ready, dbg_out, dbg_drive, snoop_data, snoop_valid, fifo_count
  );
endinterface

// File: rtl/dbg_bus_port.sv
// Purpose: debug injection FIFO onto the wired-OR word bus plus a one-shot bus snoop.
// Latency: bus_slot in cycle N drives the head word in cycle N+1; push-to-drive needs a later slot.
// Backpressure: host_ready low while the FIFO is full; snoop holds its capture until snoop_ack.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - dbg_bus_port_if.slave (host push, bus drive, bus snoop, occupancy)

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module dbg_bus_port #(
  parameter int word_width = `WORD_WIDTH,
  parameter int fifo_depth = 4
) (
  input  logic          clk,
  input  logic          reset,
  dbg_bus_port_if.slave bus
);

  localparam int cnt_width = $clog2(fifo_depth) + 1;
  localparam int ptr_width = $clog2(fifo_depth);

  typedef logic [word_width-1:0] word_t;
  typedef logic [cnt_width-1:0]  cnt_t;
  typedef logic [ptr_width-1:0]  ptr_t;

  // Snoop FSM encoding
  localparam logic [1:0] SNOOP_IDLE  = 2'b00;
  localparam logic [1:0] SNOOP_ARMED = 2'b01;
  localparam logic [1:0] SNOOP_HOLD  = 2'b10;

  // ---------------------------------------------------------------------------
  // Injection FIFO
  // ---------------------------------------------------------------------------
  word_t mem [fifo_depth];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  count;

  logic  ready;
  logic  push;
  logic  pop;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never opens room for a push: a full FIFO refuses the word this cycle.
  assign ready = (count < cnt_t'(fifo_depth));
  assign push  = bus.host_valid & ready;
  // A push into an empty FIFO is not visible to pop until the next cycle,
  // so there is no bypass path from host_data to dbg_out.
  assign pop   = bus.bus_slot & (count != '0);

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.host_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count <= count + cnt_t'(1);
      end else if (pop && !push) begin
        count <= count - cnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus drive
  // ---------------------------------------------------------------------------
  // The word register is reloaded every cycle: it carries the head word only
  // in the cycle following a granted slot and is forced to zero otherwise, so
  // a stale value can never leak onto the wired-OR bus.
  word_t dbg_out_q;
  logic  dbg_drive_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_out_q   <= '0;
      dbg_drive_q <= 1'b0;
    end else if (pop) begin
      dbg_out_q   <= mem[rd_ptr];
      dbg_drive_q <= 1'b1;
    end else begin
      dbg_out_q   <= '0;
      dbg_drive_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Snoop FSM
  // ---------------------------------------------------------------------------
  logic [1:0] snoop_state;
  word_t      snoop_data_q;
  logic       snoop_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snoop_state   <= SNOOP_IDLE;
      snoop_data_q  <= '0;
      snoop_valid_q <= 1'b0;
    end else begin
      case (snoop_state)
        SNOOP_IDLE: begin
          if (bus.snoop_req) begin
            snoop_state <= SNOOP_ARMED;
          end
        end
        SNOOP_ARMED: begin
          // Any non-idle bus value qualifies, including our own dbg_out word
          // once it has resolved onto the bus.
          if (bus.bus_in != '0) begin
            snoop_data_q  <= bus.bus_in;
            snoop_valid_q <= 1'b1;
            snoop_state   <= SNOOP_HOLD;
          end
        end
        SNOOP_HOLD: begin
          // A request arriving with the ack is dropped, not re-armed.
          if (bus.snoop_ack) begin
            snoop_valid_q <= 1'b0;
            snoop_state   <= SNOOP_IDLE;
          end
        end
        default: begin
          snoop_state   <= SNOOP_IDLE;
          snoop_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.host_ready  = ready;
  assign bus.fifo_count  = count;
  assign bus.dbg_out     = dbg_out_q;
  assign bus.dbg_drive   = dbg_drive_q;
  assign bus.snoop_data  = snoop_data_q;
  assign bus.snoop_valid = snoop_valid_q;

endmodule

// File: tb/tb_dbg_bus_port.sv
// Purpose: directed self-checking bench for dbg_bus_port.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: host stimulus holds host_valid/host_data while host_ready is low.

module tb_dbg_bus_port;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dbg_bus_port_if #(.word_width(16), .fifo_depth(4)) bif ();

  dbg_bus_port #(.word_width(16), .fifo_depth(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample the drive pair together.
  task automatic chk_drive(input string tag, input logic drv, input logic [15:0] word);
    chk({tag, "_drive"}, 32'(bif.dbg_drive), 32'(drv));
    chk({tag, "_out"},   32'(bif.dbg_out),   32'(word));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bif.host_data  = '0;
    bif.host_valid = 1'b0;
    bif.bus_slot   = 1'b0;
    bif.bus_in     = '0;
    bif.snoop_req  = 1'b0;
    bif.snoop_ack  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    chk("rst_count", 32'(bif.fifo_count), 0);
    chk("rst_ready", 32'(bif.host_ready), 1);
    chk_drive("rst", 1'b0, 16'h0000);
    chk("rst_svalid", 32'(bif.snoop_valid), 0);
    chk("rst_sdata", 32'(bif.snoop_data), 0);

    // ---- 1: two pushes, two separated slots ----
    bif.host_valid = 1'b1; bif.host_data = 16'h1234;
    tick();
    chk("t1_cnt1", 32'(bif.fifo_count), 1);
    bif.host_data = 16'h00AB;
    tick();
    chk("t1_cnt2", 32'(bif.fifo_count), 2);
    bif.host_valid = 1'b0;
    bif.bus_slot = 1'b1;
    chk_drive("t1_pre", 1'b0, 16'h0000);
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t1_w0", 1'b1, 16'h1234);
    chk("t1_cnt_a", 32'(bif.fifo_count), 1);
    tick();
    chk_drive("t1_gap0", 1'b0, 16'h0000);
    tick();
    chk_drive("t1_gap1", 1'b0, 16'h0000);
    tick();
    chk_drive("t1_gap2", 1'b0, 16'h0000);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t1_w1", 1'b1, 16'h00AB);
    chk("t1_cnt_b", 32'(bif.fifo_count), 0);
    tick();
    chk_drive("t1_end", 1'b0, 16'h0000);

    // ---- 2: fill to full, host holds word 5 ----
    bif.host_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bif.host_data = 16'(i);
      tick();
      chk("t2_fill_cnt", 32'(bif.fifo_count), 32'(i));
    end
    chk("t2_full_ready", 32'(bif.host_ready), 0);
    bif.host_data = 16'd5;
    tick();
    chk("t2_hold_cnt", 32'(bif.fifo_count), 4);
    chk("t2_hold_ready", 32'(bif.host_ready), 0);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t2_pop", 1'b1, 16'd1);
    chk("t2_pop_cnt", 32'(bif.fifo_count), 3);
    chk("t2_pop_ready", 32'(bif.host_ready), 1);
    tick();
    bif.host_valid = 1'b0;
    chk("t2_push5_cnt", 32'(bif.fifo_count), 4);
    chk_drive("t2_idle", 1'b0, 16'h0000);
    bif.bus_slot = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_drive("t2_drain", 1'b1, 16'(i));
      chk("t2_drain_cnt", 32'(bif.fifo_count), 32'(5 - i));
    end
    // Slot stays high on an empty FIFO: no drive.
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t2_empty_slot", 1'b0, 16'h0000);

    // ---- 3: no bypass ----
    bif.host_valid = 1'b1; bif.host_data = 16'h0055; bif.bus_slot = 1'b1;
    tick();
    bif.host_valid = 1'b0; bif.bus_slot = 1'b0;
    chk_drive("t3_nobypass", 1'b0, 16'h0000);
    chk("t3_cnt", 32'(bif.fifo_count), 1);
    tick();
    chk_drive("t3_wait", 1'b0, 16'h0000);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t3_drive", 1'b1, 16'h0055);
    chk("t3_cnt0", 32'(bif.fifo_count), 0);
    tick();

    // ---- 4: streaming push+pop through pointer wrap ----
    bif.host_valid = 1'b1; bif.host_data = 16'h0010;
    tick();
    chk("t4_prime_cnt", 32'(bif.fifo_count), 1);
    for (int i = 1; i <= 9; i++) begin
      bif.host_data = 16'(16'h0010 + i);
      bif.bus_slot  = 1'b1;
      tick();
      chk_drive("t4_stream", 1'b1, 16'(16'h0010 + i - 1));
      chk("t4_stream_cnt", 32'(bif.fifo_count), 1);
    end
    bif.host_valid = 1'b0;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t4_last", 1'b1, 16'h0019);
    chk("t4_cnt0", 32'(bif.fifo_count), 0);
    tick();
    chk_drive("t4_idle", 1'b0, 16'h0000);

    // ---- 5: snoop ----
    bif.snoop_req = 1'b1; bif.bus_in = 16'h0000;
    tick();
    bif.snoop_req = 1'b0;
    tick();
    tick();
    chk("t5_armed_novalid", 32'(bif.snoop_valid), 0);
    bif.bus_in = 16'hBEEF;
    tick();
    chk("t5_cap_valid", 32'(bif.snoop_valid), 1);
    chk("t5_cap_data", 32'(bif.snoop_data), 32'h0000BEEF);
    bif.bus_in = 16'h1111;
    tick();
    chk("t5_frozen", 32'(bif.snoop_data), 32'h0000BEEF);
    bif.snoop_req = 1'b1;
    tick();
    bif.snoop_req = 1'b0;
    chk("t5_req_hold", 32'(bif.snoop_data), 32'h0000BEEF);
    chk("t5_req_hold_v", 32'(bif.snoop_valid), 1);
    bif.snoop_ack = 1'b1;
    tick();
    bif.snoop_ack = 1'b0;
    chk("t5_ack", 32'(bif.snoop_valid), 0);
    bif.bus_in = 16'h2222;
    tick();
    chk("t5_no_rearm", 32'(bif.snoop_valid), 0);
    // ack together with req in HOLD returns to IDLE without re-arming.
    bif.snoop_req = 1'b1; bif.bus_in = 16'h3333;
    tick();
    bif.snoop_req = 1'b0;
    chk("t5_idle_to_armed", 32'(bif.snoop_valid), 0);
    tick();
    chk("t5_cap2", 32'(bif.snoop_data), 32'h00003333);
    bif.snoop_req = 1'b1; bif.snoop_ack = 1'b1;
    tick();
    bif.snoop_req = 1'b0; bif.snoop_ack = 1'b0;
    chk("t5_ackreq", 32'(bif.snoop_valid), 0);
    tick();
    chk("t5_ackreq_norearm", 32'(bif.snoop_valid), 0);
    bif.bus_in = 16'h0000;

    // ---- 6: reset mid-operation ----
    bif.snoop_req = 1'b1;
    bif.host_valid = 1'b1; bif.host_data = 16'h7777;
    tick();
    bif.snoop_req = 1'b0;
    bif.bus_in = 16'h4242;
    bif.host_data = 16'h00A1;
    tick();
    bif.bus_in = 16'h0000;
    bif.host_data = 16'h00A2;
    tick();
    bif.host_data = 16'h00A3;
    tick();
    bif.host_valid = 1'b0;
    chk("t6_svalid", 32'(bif.snoop_valid), 1);
    chk("t6_full", 32'(bif.fifo_count), 4);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t6_pre", 1'b1, 16'h7777);
    chk("t6_pre_cnt", 32'(bif.fifo_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_drive("t6_rst", 1'b0, 16'h0000);
    chk("t6_rst_cnt", 32'(bif.fifo_count), 0);
    chk("t6_rst_svalid", 32'(bif.snoop_valid), 0);
    chk("t6_rst_sdata", 32'(bif.snoop_data), 0);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk_drive("t6_post_slot", 1'b0, 16'h0000);
    chk("t6_post_cnt", 32'(bif.fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
